regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Sequences and shares the single register-file write port of the LEGv8 datapath. After reset it clears X0..X30 via an internal sweep. It then arbitrates, round-robin, between two write-back requesters: port A (ALU result) and port B (memory load data). Each granted write is driven as a registered address, data and 32-bit one-hot write-select; the register file uses the select as its per-register write enable.

Parameters:
DATA_WIDTH, 64, width of write data
INIT_CLEAR, 1, 1 = run the post-reset clear sweep; 0 = enter RUN directly
XZR_INDEX, 31, register index that is never written (zero register)

Ports:
clock  in  1  single clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
a_valid  in  1  requester A has a write pending
a_ready  out  1  requester A write accepted this cycle
a_addr  in  5  destination register for A
a_data  in  DATA_WIDTH  write data for A
b_valid  in  1  requester B has a write pending
b_ready  out  1  requester B write accepted this cycle
b_addr  in  5  destination register for B
b_data  in  DATA_WIDTH  write data for B
wr_en  out  1  register-file write strobe
wr_addr  out  5  register-file write address
wr_data  out  DATA_WIDTH  register-file write data
wr_sel  out  32  one-hot write select; all-zero when wr_en=0
init_done  out  1  high once the clear sweep has completed

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state = INIT if INIT_CLEAR=1, else RUN.
  - clear counter = 0; round-robin pointer = A.
  - wr_en = 0, wr_addr = 0, wr_data = 0, wr_sel = 0.
  - init_done = 0 if INIT_CLEAR=1, else 1.
- Reset asserted in any state aborts any sweep or write and restores the reset values. A sweep restarts from X0.
- FSM states: INIT, RUN.
- INIT:
  - a_ready = b_ready = 0.
  - Each cycle, register wr_en=1, wr_addr=cnt, wr_data=0, wr_sel=onehot(cnt); then cnt++.
  - Covers cnt 0..30 (31 writes). X31 is skipped.
  - After issuing cnt=30, go to RUN. init_done goes high on the same edge that outputs the X30 clear.
- RUN arbitration is combinational:
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: grant the side named by the pointer.
  - Never both readies in one cycle.
  - A request is accepted when valid & ready on a rising edge.
- Pointer update: after a contested grant (both valid), the pointer moves to the loser. Uncontested grants leave the pointer unchanged.
- Latency: an accepted request appears on wr_* exactly 1 cycle later. Throughput is 1 write per cycle; there is no back-pressure from the register file.
- If the accepted address equals XZR_INDEX:
  - The handshake still completes.
  - wr_en=0, wr_sel=0; wr_addr and wr_data hold the request values.
- Cycle with no acceptance: wr_en=0 and wr_sel=0 on the next cycle; wr_addr and wr_data hold their last values.
- Invariants: wr_sel == (wr_en ? onehot(wr_addr) : 0). wr_sel[XZR_INDEX] is never 1.
- Requesters must hold addr/data stable while valid & !ready. Dropping valid without a handshake is legal; the request is simply withdrawn.
- Requests presented during INIT wait; they are not lost as long as the requester keeps valid high.

Decomposition:
- Shared package regfile_pkg holds:
  - constants XZR_INDEX=31, NUM_REGS=32, REG_ADDR_W=5, LAST_CLEAR=30
  - FSM state encoding (INIT=1'b0, RUN=1'b1)
  - round-robin pointer encoding (PTR_A=0, PTR_B=1)
- Sub-module regfile_onehot_decode: combinational 5-bit to 32-bit one-hot with an enable input. Output is all-zero when disabled or when the address is XZR_INDEX. Instantiated once, feeding the wr_sel register.

Test Plan:
- Reset, then release with INIT_CLEAR=1 → 31 consecutive cycles of wr_en=1 with wr_addr 0..30, wr_data=0 and wr_sel=1<<n. Then wr_en=0, init_done=1, and wr_sel[31] never set.
- RUN, only A valid with addr=5, data=0x1234 for one cycle → a_ready=1 that cycle. Next cycle wr_en=1, wr_addr=5, wr_data=0x1234, wr_sel=0x00000020.
- RUN, A and B both held valid for 4 cycles (A: addr=1, B: addr=2) → grants A,B,A,B. wr_addr sequence 1,2,1,2, each one cycle after its grant.
- B valid with addr=31 → b_ready=1. Next cycle wr_en=0 and wr_sel=0.
- Reset asserted after the 10th INIT write → outputs return to 0 on the next edge. After release the sweep restarts at wr_addr=0 and init_done stays 0 until X30 is written.
- A valid during INIT with addr=7 → a_ready=0 through the sweep. a_ready=1 in the first RUN cycle, then a write to X7 one cycle later.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and encodings for the register-file write
//               arbiter and its one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XZR_INDEX  = 31;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LAST_CLEAR = 30;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_onehot_decode.sv
`default_nettype none
// ============================================================================
// Module      : regfile_onehot_decode
// Description : 5-bit address to 32-bit one-hot write select; the zero
//               register never decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_onehot_decode #(
    parameter int XZR_INDEX = 31
) (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] sel
);
    import regfile_pkg::*;

    always_comb begin
        sel = '0;
        if (en && (addr != 5'(XZR_INDEX))) begin
            sel[addr] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Clears X0..X30 after reset, then round-robin arbitrates two
//               write-back requesters onto the single register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter bit INIT_CLEAR = 1'b1,
    parameter int XZR_INDEX  = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [4:0]            a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [4:0]            b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  wr_en,
    output logic [4:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [31:0]           wr_sel,
    output logic                  init_done
);
    import regfile_pkg::*;

    state_t                r_state;
    ptr_t                  r_ptr;
    logic [4:0]            r_cnt;

    logic                  w_accept;
    logic [4:0]            w_grant_addr;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic                  w_dec_en;
    logic [4:0]            w_dec_addr;
    logic [31:0]           w_sel;

    // At most one ready per cycle; the pointer only matters when both are valid.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (r_state == RUN) begin
            if (a_valid && (!b_valid || (r_ptr == PTR_A))) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign w_accept     = (a_valid && a_ready) || (b_valid && b_ready);
    assign w_grant_addr = a_ready ? a_addr : b_addr;
    assign w_grant_data = a_ready ? a_data : b_data;
    assign w_dec_en     = (r_state == INIT) || w_accept;
    assign w_dec_addr   = (r_state == INIT) ? r_cnt : w_grant_addr;

    regfile_onehot_decode #(
        .XZR_INDEX (XZR_INDEX)
    ) u_decode (
        .en   (w_dec_en),
        .addr (w_dec_addr),
        .sel  (w_sel)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            if (INIT_CLEAR) begin
                r_state <= INIT;
            end else begin
                r_state <= RUN;
            end
            r_ptr     <= PTR_A;
            r_cnt     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_sel    <= '0;
            init_done <= !INIT_CLEAR;
        end else begin
            wr_sel <= w_sel;
            if (r_state == INIT) begin
                wr_en   <= 1'b1;
                wr_addr <= r_cnt;
                wr_data <= '0;
                r_cnt   <= r_cnt + 5'd1;
                if (r_cnt == 5'(LAST_CLEAR)) begin
                    r_state   <= RUN;
                    init_done <= 1'b1;
                end
            end else begin
                // A zero-register write completes its handshake but never strobes.
                wr_en <= w_accept && (w_grant_addr != 5'(XZR_INDEX));
                if (w_accept) begin
                    wr_addr <= w_grant_addr;
                    wr_data <= w_grant_data;
                end
                if (a_valid && b_valid) begin
                    if (a_ready) begin
                        r_ptr <= PTR_B;
                    end else begin
                        r_ptr <= PTR_A;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DW = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [4:0]    a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [31:0]   wr_sel;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(
        .DATA_WIDTH (DW),
        .INIT_CLEAR (1'b1),
        .XZR_INDEX  (31)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_sel    (wr_sel),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        a_data  = '0;
        b_data  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 40 && !init_done; i++) tick();
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_init: init_done got %b want 1 within 40 cycles", init_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, wr_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h sel=%h want all 0",
                     wr_en, wr_addr, wr_data, wr_sel);
        end
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_done: got %b want 0", init_done);
        end
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic check_sweep(input string tag);
        for (int n = 0; n < 31; n++) begin
            tick();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 5'(n) || wr_data !== '0 ||
                wr_sel !== (32'd1 << n) || init_done !== (n == 30)) begin
                errors++;
                $display("FAIL %s_%0d: en=%b addr=%0d data=%h sel=%h done=%b want en=1 addr=%0d data=0 sel=%h done=%b",
                         tag, n, wr_en, wr_addr, wr_data, wr_sel, init_done,
                         n, 32'd1 << n, (n == 30));
            end
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || wr_sel !== '0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: en=%b sel=%h done=%b want en=0 sel=0 done=1",
                     tag, wr_en, wr_sel, init_done);
        end
    endtask

    task automatic test_init_sweep();
        check_sweep("sweep");
    endtask

    task automatic test_single_a();
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 64'h1234;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_a_ready: got %b want 10", {a_ready, b_ready});
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'h1234 || wr_sel !== 32'h20) begin
            errors++;
            $display("FAIL single_a_write: en=%b addr=%0d data=%h sel=%h want 1/5/1234/00000020",
                     wr_en, wr_addr, wr_data, wr_sel);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || wr_sel !== '0 || wr_addr !== 5'd5 || wr_data !== 64'h1234) begin
            errors++;
            $display("FAIL idle_hold: en=%b addr=%0d data=%h sel=%h want 0/5/1234/0",
                     wr_en, wr_addr, wr_data, wr_sel);
        end
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hAAAA_0001;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hBBBB_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({a_ready, b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b want %b", k, {a_ready, b_ready},
                         (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== ((k % 2 == 0) ? 5'd1 : 5'd2) ||
                wr_data !== ((k % 2 == 0) ? 64'hAAAA_0001 : 64'hBBBB_0002)) begin
                errors++;
                $display("FAIL rr_write_%0d: en=%b addr=%0d data=%h", k, wr_en, wr_addr, wr_data);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_xzr();
        b_valid = 1'b1;
        b_addr  = 5'd31;
        b_data  = 64'hDEAD_BEEF;
        #1;
        checks++;
        if ({a_ready, b_ready} !== 2'b01) begin
            errors++;
            $display("FAIL xzr_ready: got %b want 01", {a_ready, b_ready});
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || wr_sel !== '0 || wr_addr !== 5'd31 || wr_data !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL xzr_write: en=%b addr=%0d data=%h sel=%h want 0/31/deadbeef/0",
                     wr_en, wr_addr, wr_data, wr_sel);
        end
    endtask

    task automatic test_reset_mid_init();
        do_reset();
        repeat (10) tick();
        checks++;
        if (wr_addr !== 5'd9 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_init_pre: addr=%0d en=%b want 9/1", wr_addr, wr_en);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wr_sel, init_done} !== '0) begin
            errors++;
            $display("FAIL mid_init_reset: en=%b addr=%0d sel=%h done=%b want all 0",
                     wr_en, wr_addr, wr_sel, init_done);
        end
        reset = 1'b0;
        check_sweep("resweep");
    endtask

    task automatic test_init_wait();
        do_reset();
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 64'h7777_0007;
        for (int n = 0; n < 31; n++) begin
            #1;
            checks++;
            if (a_ready !== 1'b0) begin
                errors++;
                $display("FAIL init_wait_ready_%0d: got %b want 0", n, a_ready);
            end
            tick();
        end
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_wait_first_run: a_ready got %b want 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'h7777_0007 || wr_sel !== 32'h80) begin
            errors++;
            $display("FAIL init_wait_write: en=%b addr=%0d data=%h sel=%h want 1/7/77770007/00000080",
                     wr_en, wr_addr, wr_data, wr_sel);
        end
    endtask

    // Reference: pointer names the favoured side; it flips to the loser of a contest.
    task automatic test_random();
        bit            m_ptr_b = 1'b0;
        bit            a_pend = 1'b0, b_pend = 1'b0;
        bit            ga, gb;
        logic [4:0]    e_addr;
        logic [DW-1:0] e_data;
        logic          e_en;
        logic [31:0]   e_sel;
        do_reset();
        wait_init();
        e_addr = wr_addr;
        e_data = wr_data;
        for (int c = 0; c < 300; c++) begin
            if (a_pend && $urandom_range(0, 3) != 0) begin
                a_valid = 1'b1;
            end else begin
                a_valid = ($urandom_range(0, 1) == 1);
                a_addr  = 5'($urandom_range(0, 31));
                a_data  = {$urandom, $urandom};
            end
            if (b_pend && $urandom_range(0, 3) != 0) begin
                b_valid = 1'b1;
            end else begin
                b_valid = ($urandom_range(0, 1) == 1);
                b_addr  = 5'($urandom_range(0, 31));
                b_data  = {$urandom, $urandom};
            end
            #1;
            ga = a_valid && (!b_valid || !m_ptr_b);
            gb = b_valid && !ga;
            checks++;
            if (a_ready !== ga || b_ready !== gb) begin
                errors++;
                $display("FAIL rand_ready_%0d: got a=%b b=%b want a=%b b=%b",
                         c, a_ready, b_ready, ga, gb);
            end
            if (a_valid && b_valid) m_ptr_b = ga;
            if (ga) begin
                e_addr = a_addr; e_data = a_data;
            end else if (gb) begin
                e_addr = b_addr; e_data = b_data;
            end
            e_en  = (ga || gb) && (e_addr != 5'd31);
            e_sel = e_en ? (32'd1 << e_addr) : 32'd0;
            a_pend = a_valid && !ga;
            b_pend = b_valid && !gb;
            tick();
            checks++;
            if (wr_en !== e_en || wr_addr !== e_addr || wr_data !== e_data || wr_sel !== e_sel) begin
                errors++;
                $display("FAIL rand_write_%0d: en=%b addr=%0d data=%h sel=%h want en=%b addr=%0d data=%h sel=%h",
                         c, wr_en, wr_addr, wr_data, wr_sel, e_en, e_addr, e_data, e_sel);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_single_a();
        test_back_to_back();
        test_xzr();
        test_reset_mid_init();
        test_init_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
